// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between the register bank (master) and the NCO sweep sequencer (slave).
interface nco_sweep_ctrl_if #(
    parameter int FSZ  = 31,
    parameter int DWSZ = 16,
    parameter int CSZ  = 16
);
    logic [FSZ-1:0]  cfg_start;
    logic [FSZ-1:0]  cfg_stop;
    logic [FSZ-1:0]  cfg_step;
    logic [DWSZ-1:0] cfg_dwell;
    logic            cfg_repeat;
    logic            start;
    logic            abort;
    logic [FSZ-1:0]  freq;
    logic            step_strobe;
    logic            busy;
    logic            done;
    logic            err;
    logic [CSZ-1:0]  periods;

    modport master (
        output cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat, start, abort,
        input  freq, step_strobe, busy, done, err, periods
    );

    modport slave (
        input  cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat, start, abort,
        output freq, step_strobe, busy, done, err, periods
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Stepped-chirp sequencer driving the NCO tuning word; sawtooth by default,
// triangle (up then down) sweeps when NCO_SWEEP_TRIANGLE_EN is defined.
module nco_sweep_ctrl #(
    parameter int FSZ  = 31,
    parameter int DWSZ = 16,
    parameter int CSZ  = 16
) (
    input logic              clk,
    input logic              reset,
    nco_sweep_ctrl_if.slave  bus
);

`ifdef NCO_SWEEP_TRIANGLE_EN
    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN_UP} state_t;
`endif

    state_t          state_q, state_d;
    logic [FSZ-1:0]  freq_q, freq_d;
    logic            strobe_q, strobe_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [CSZ-1:0]  periods_q, periods_d;
    logic [DWSZ-1:0] dwell_q, dwell_d;
    logic [FSZ-1:0]  startCfg_q, startCfg_d;
    logic [FSZ-1:0]  stopCfg_q, stopCfg_d;
    logic [FSZ-1:0]  stepCfg_q, stepCfg_d;
    logic [DWSZ-1:0] dwellCfg_q, dwellCfg_d;
    logic            repeatCfg_q, repeatCfg_d;

    // One extra bit so a carry out of the tuning word counts as passing the stop value.
    logic [FSZ:0] upSum;
    logic         upOver;
    assign upSum  = {1'b0, freq_q} + {1'b0, stepCfg_q};
    assign upOver = (upSum > {1'b0, stopCfg_q});

`ifdef NCO_SWEEP_TRIANGLE_EN
    logic [FSZ:0] dnDiff;
    logic         dnUnder;
    assign dnDiff  = {1'b0, freq_q} - {1'b0, stepCfg_q};
    assign dnUnder = dnDiff[FSZ] || (dnDiff[FSZ-1:0] < startCfg_q);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            freq_q      <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            periods_q   <= '0;
            dwell_q     <= '0;
            startCfg_q  <= '0;
            stopCfg_q   <= '0;
            stepCfg_q   <= '0;
            dwellCfg_q  <= '0;
            repeatCfg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            periods_q   <= periods_d;
            dwell_q     <= dwell_d;
            startCfg_q  <= startCfg_d;
            stopCfg_q   <= stopCfg_d;
            stepCfg_q   <= stepCfg_d;
            dwellCfg_q  <= dwellCfg_d;
            repeatCfg_q <= repeatCfg_d;
        end
    end

    // Abort outranks everything; otherwise a step happens only when the dwell count has run out.
    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        periods_d   = periods_q;
        dwell_d     = dwell_q;
        startCfg_d  = startCfg_q;
        stopCfg_d   = stopCfg_q;
        stepCfg_d   = stepCfg_q;
        dwellCfg_d  = dwellCfg_q;
        repeatCfg_d = repeatCfg_q;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if ((bus.cfg_step == '0) || (bus.cfg_start > bus.cfg_stop)) begin
                            err_d = 1'b1;
                        end else begin
                            startCfg_d  = bus.cfg_start;
                            stopCfg_d   = bus.cfg_stop;
                            stepCfg_d   = bus.cfg_step;
                            dwellCfg_d  = bus.cfg_dwell;
                            repeatCfg_d = bus.cfg_repeat;
                            freq_d      = bus.cfg_start;
                            strobe_d    = 1'b1;
                            periods_d   = '0;
                            dwell_d     = bus.cfg_dwell;
                            state_d     = RUN_UP;
                        end
                    end
                end
                RUN_UP: begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - DWSZ'(1);
                    end else begin
                        dwell_d = dwellCfg_q;
                        if (!upOver) begin
                            freq_d   = upSum[FSZ-1:0];
                            strobe_d = 1'b1;
                        end else begin
`ifdef NCO_SWEEP_TRIANGLE_EN
                            state_d  = RUN_DN;
                            strobe_d = 1'b1;
                            if (!dnUnder) begin
                                freq_d = dnDiff[FSZ-1:0];
                            end
`else
                            periods_d = periods_q + CSZ'(1);
                            if (repeatCfg_q) begin
                                freq_d   = startCfg_q;
                                strobe_d = 1'b1;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
`endif
                        end
                    end
                end
`ifdef NCO_SWEEP_TRIANGLE_EN
                RUN_DN: begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - DWSZ'(1);
                    end else begin
                        dwell_d = dwellCfg_q;
                        if (!dnUnder) begin
                            freq_d   = dnDiff[FSZ-1:0];
                            strobe_d = 1'b1;
                        end else begin
                            // Reaching the bottom closes a period; the bottom value is not repeated on the way up.
                            periods_d = periods_q + CSZ'(1);
                            if (repeatCfg_q) begin
                                state_d  = RUN_UP;
                                strobe_d = 1'b1;
                                if (!upOver) begin
                                    freq_d = upSum[FSZ-1:0];
                                end
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.freq        = freq_q;
    assign bus.step_strobe = strobe_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.periods     = periods_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: a value-list sweep model queues expected
// strobe/done/err events, and a negedge monitor pops and compares them.
module tb_nco_sweep_ctrl;
    localparam int FSZ  = 31;
    localparam int DWSZ = 16;
    localparam int CSZ  = 16;

    typedef struct {
        int             cyc;
        int             kind;
        logic [FSZ-1:0] freq;
        logic [CSZ-1:0] periods;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   assertCount = 0;
    int   failCount   = 0;
    ev_t  expQ[$];
    logic [FSZ-1:0] modelFreq    = '0;
    logic [CSZ-1:0] modelPeriods = '0;

    nco_sweep_ctrl_if #(.FSZ(FSZ), .DWSZ(DWSZ), .CSZ(CSZ)) bus ();

    nco_sweep_ctrl #(.FSZ(FSZ), .DWSZ(DWSZ), .CSZ(CSZ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: any strobe/done/err must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        int  kind;
        ev_t e;
        if (!reset) begin
            if (bus.step_strobe || bus.done || bus.err) begin
                kind = bus.err ? 2 : (bus.done ? 1 : 0);
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpectedEvent: got kind %0d freq 0x%0h, expected no event (cycle %0d)",
                             kind, bus.freq, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("eventKind", 32'(kind), 32'(e.kind));
                    checkOutput("eventCycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("eventFreq", 32'(bus.freq), 32'(e.freq));
                    checkOutput("eventPeriods", 32'(bus.periods), 32'(e.periods));
                end
            end else if (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
                e = expQ.pop_front();
                assertCount++;
                failCount++;
                $display("[TB] FAIL missedEvent: got no event, expected kind %0d freq 0x%0h at cycle %0d",
                         e.kind, e.freq, e.cyc);
            end
        end
    end

    task automatic pushEvent(input int c, input int k, input logic [FSZ-1:0] f,
                             input logic [CSZ-1:0] p, input int lastCyc);
        ev_t e;
        if (c > lastCyc) return;
        e.cyc = c;
        e.kind = k;
        e.freq = f;
        e.periods = p;
        expQ.push_back(e);
        modelFreq = f;
        modelPeriods = p;
    endtask

    // Reference model: list the tuning values of one period, then replay it cycle by cycle.
    task automatic pushSweep(input int s, input logic [FSZ-1:0] st, input logic [FSZ-1:0] sp,
                             input logic [FSZ-1:0] stp, input int dw, input bit rpt, input int lastCyc);
        logic [31:0]    v;
        logic [FSZ-1:0] up[$];
        logic [FSZ-1:0] per0[$];
        logic [FSZ-1:0] perN[$];
        int c;
        int k;
        v = {1'b0, st};
        while (v <= {1'b0, sp}) begin
            up.push_back(v[FSZ-1:0]);
            v = v + {1'b0, stp};
        end
        per0 = up;
        perN = up;
`ifdef NCO_SWEEP_TRIANGLE_EN
        if (up.size() > 1) begin
            for (int i = up.size() - 2; i >= 0; i--) per0.push_back(up[i]);
            perN = per0[1:$];
        end else begin
            per0.push_back(up[0]);
            perN.delete();
            perN.push_back(up[0]);
            perN.push_back(up[0]);
        end
`endif
        c = s + 1;
        foreach (per0[i]) begin
            pushEvent(c, 0, per0[i], '0, lastCyc);
            c += dw + 1;
        end
        if (!rpt) begin
            pushEvent(c, 1, per0[per0.size() - 1], CSZ'(1), lastCyc);
        end else begin
            k = 1;
            while (c <= lastCyc) begin
                foreach (perN[i]) begin
                    pushEvent(c, 0, perN[i], CSZ'(k), lastCyc);
                    c += dw + 1;
                end
                k++;
            end
        end
    endtask

    task automatic scrambleCfg();
        bus.cfg_start  = FSZ'($urandom);
        bus.cfg_stop   = FSZ'($urandom);
        bus.cfg_step   = FSZ'($urandom);
        bus.cfg_dwell  = DWSZ'($urandom);
        bus.cfg_repeat = 1'($urandom);
    endtask

    // One start request; optionally stopped by abort or reset stopAfter cycles later.
    task automatic applyStimulus(input logic [FSZ-1:0] st, input logic [FSZ-1:0] sp, input logic [FSZ-1:0] stp,
                                 input int dw, input bit rpt, input int stopAfter,
                                 input bit useReset, input bit midStart);
        int s;
        int a;
        int cur;
        int budget;
        bit rejected;
        @(negedge clk); #1;
        s = cyc;
        a = (stopAfter > 0) ? s + stopAfter : s + 1000000;
        bus.cfg_start  = st;
        bus.cfg_stop   = sp;
        bus.cfg_step   = stp;
        bus.cfg_dwell  = DWSZ'(dw);
        bus.cfg_repeat = rpt;
        bus.start      = 1'b1;
        rejected = (stp == '0) || (st > sp);
        if (rejected) pushEvent(s + 1, 2, modelFreq, modelPeriods, a);
        else          pushSweep(s, st, sp, stp, dw, rpt, a);
        budget = 0;
        forever begin
            @(negedge clk); #1;
            cur = cyc;
            budget++;
            if (cur == s + 1) checkOutput("busyAfterStart", 32'(bus.busy), 32'(!rejected));
            if (useReset && stopAfter > 0 && cur == a + 1) begin
                checkOutput("resetFreq", 32'(bus.freq), 32'd0);
                checkOutput("resetBusy", 32'(bus.busy), 32'd0);
                checkOutput("resetPeriods", 32'(bus.periods), 32'd0);
                checkOutput("resetPulses", {29'd0, bus.step_strobe, bus.done, bus.err}, 32'd0);
                modelFreq = '0;
                modelPeriods = '0;
            end
            scrambleCfg();
            bus.start = midStart && (cur == s + 3);
            if (bus.start) begin
                bus.cfg_start = FSZ'(5);
                bus.cfg_stop  = FSZ'(500);
                bus.cfg_step  = FSZ'(7);
            end
            bus.abort = !useReset && (stopAfter > 0) && (cur == a);
            reset     = useReset && (stopAfter > 0) && (cur == a);
            if (expQ.size() == 0 && cur > s + 3 && (stopAfter <= 0 || cur > a + 1)) break;
            if (budget > 5000) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL sweepTimeout: got %0d events outstanding, expected 0", expQ.size());
                expQ.delete();
                break;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("idleBusy", 32'(bus.busy), 32'd0);
        checkOutput("idleFreq", 32'(bus.freq), 32'(modelFreq));
        checkOutput("idlePeriods", 32'(bus.periods), 32'(modelPeriods));
    endtask

    task automatic startWithAbortIdle();
        @(negedge clk); #1;
        bus.cfg_start  = FSZ'(10);
        bus.cfg_stop   = FSZ'(20);
        bus.cfg_step   = FSZ'(1);
        bus.cfg_dwell  = '0;
        bus.cfg_repeat = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("startAbortBusy", 32'(bus.busy), 32'd0);
        checkOutput("startAbortFreq", 32'(bus.freq), 32'(modelFreq));
    endtask

    initial begin : stimulus
        logic [FSZ-1:0] st;
        logic [FSZ-1:0] sp;
        logic [FSZ-1:0] stp;
        int dw;
        bit rpt;
        int stopAfter;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        scrambleCfg();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstFreq", 32'(bus.freq), 32'd0);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstPeriods", 32'(bus.periods), 32'd0);
        checkOutput("rstPulses", {29'd0, bus.step_strobe, bus.done, bus.err}, 32'd0);
        reset = 1'b0;

        applyStimulus(FSZ'(100), FSZ'(130), FSZ'(10), 3, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(FSZ'(100), FSZ'(130), FSZ'(10), 3, 1'b1, 22, 1'b0, 1'b0);
        applyStimulus(31'h7FFFFFF0, 31'h7FFFFFFF, FSZ'(32), 0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(FSZ'(100), FSZ'(130), FSZ'(0), 1, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(FSZ'(200), FSZ'(100), FSZ'(10), 1, 1'b0, 0, 1'b0, 1'b0);
        startWithAbortIdle();
        applyStimulus(FSZ'(40), FSZ'(40), FSZ'(3), 1, 1'b1, 14, 1'b0, 1'b0);
        applyStimulus(FSZ'(20), FSZ'(60), FSZ'(15), 2, 1'b1, 30, 1'b0, 1'b1);
        applyStimulus(FSZ'(100), FSZ'(130), FSZ'(10), 1, 1'b1, 15, 1'b1, 1'b0);

        for (int n = 0; n < 14; n++) begin
            st  = FSZ'($urandom_range(0, 1000));
            stp = FSZ'($urandom_range(0, 40));
            sp  = st + FSZ'($urandom_range(0, 150));
            if ($urandom_range(0, 7) == 0 && st > 0) sp = st - FSZ'(1);
            dw  = int'($urandom_range(0, 3));
            rpt = 1'($urandom_range(0, 1));
            if (rpt) stopAfter = int'($urandom_range(8, 80));
            else     stopAfter = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            applyStimulus(st, sp, stp, dw, rpt, stopAfter, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
